// File: rtl/splash_pkg.sv
// splash_pkg: shared mode encodings, sequencer state type and OLED geometry.
package splash_pkg;
  localparam logic [1:0] MODE_ONCE     = 2'd0;
  localparam logic [1:0] MODE_LOOP     = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
  localparam int OLED_W    = 96;
  localparam int OLED_H    = 64;
  localparam int OLED_NPIX = OLED_W * OLED_H;
endpackage

// File: rtl/single_port_ram.sv
// single_port_ram: single-port block RAM, optional output register (HIGH_PERFORMANCE = 2-cycle read).
// Ports: clka clock; addra address; dina/wea write data/enable; ena port enable;
//        regcea output register enable; douta read data.
module single_port_ram #(
  parameter int RAM_WIDTH       = 16,
  parameter int RAM_DEPTH       = 1024,
  parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter     INIT_FILE       = ""
) (
  input  logic                         clka,
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic                         wea,
  input  logic                         ena,
  input  logic                         regcea,
  output logic [RAM_WIDTH-1:0]         douta
);
  logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_data;
  always @(posedge clka)
    if (ena && wea) ram[addra] <= dina;
  always_ff @(posedge clka)
    if (ena) ram_data <= ram[addra];
  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_low
    assign douta = ram_data;
  end else begin : g_high
    always_ff @(posedge clka)
      if (regcea) douta <= ram_data;
  end
endmodule

// File: rtl/splash_player.sv
// splash_player: multi-frame splash sequencer (once/loop/ping-pong, skip) with tear-free frame swaps.
// Ports: clk, rst_n (async active-low); pixel_index OLED scan address; start/skip pulses;
//        mode playback mode sampled on start; oled_data pixel colour (4-cycle latency);
//        frame displayed frame; busy in PLAY; done in DONE.
module splash_player
  import splash_pkg::*;
#(
  parameter int WIDTH       = OLED_W,
  parameter int HEIGHT      = OLED_H,
  parameter int PIX_BITS    = 16,
  parameter int N_FRAMES    = 4,
  parameter int FRAME_TICKS = 25_000_000,
  parameter     MEM_FILE    = "splash.mem",
  localparam int FW         = N_FRAMES > 1 ? $clog2(N_FRAMES) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [12:0]         pixel_index,
  input  logic                start,
  input  logic                skip,
  input  logic [1:0]          mode,
  output logic [PIX_BITS-1:0] oled_data,
  output logic [FW-1:0]       frame,
  output logic                busy,
  output logic                done
);
  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int DEPTH = N_FRAMES * NPIX;
  localparam int AW    = $clog2(DEPTH);
  localparam int TW    = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
  localparam logic [FW-1:0] LAST   = FW'(N_FRAMES - 1);
  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);
  state_t state, state_n;
  logic [TW-1:0] tick, tick_n;
  logic [FW-1:0] pend, pend_n, disp, disp_n;
  logic dir, dir_n;
  logic [1:0] mode_r, mode_n;
  logic [AW-1:0] addr;
  logic [2:0] vld;
  logic [PIX_BITS-1:0] douta;
  logic expire, valid;
  assign expire = tick == TW'(FRAME_TICKS - 1);
  assign valid  = 32'(pixel_index) < NPIX;
  // Swap only at the top of the scan so a frame is never split across two images.
  assign disp_n = pixel_index == '0 ? pend : disp;
  assign frame  = disp;
  assign busy   = state == PLAY;
  assign done   = state == DONE;
  // dir: 0 = counting up, 1 = counting down (ping-pong only).
  always_comb begin
    state_n = state;
    tick_n  = tick;
    pend_n  = pend;
    dir_n   = dir;
    mode_n  = mode_r;
    if (state == PLAY) begin
      tick_n = tick + 1'b1;
      if (skip) begin
        state_n = DONE;
        pend_n  = LAST;
      end else if (expire) begin
        tick_n = '0;
        if (mode_r == MODE_LOOP) pend_n = pend == LAST ? '0 : pend + 1'b1;
        else if (mode_r == MODE_PINGPONG) begin
          if (N_FRAMES > 1) begin
            if (dir ? pend == '0 : pend == LAST) dir_n = ~dir;
            pend_n = dir_n ? pend - 1'b1 : pend + 1'b1;
          end
        end else if (pend == LAST) state_n = DONE;
        else pend_n = pend + 1'b1;
      end
    end else if (start) begin
      state_n = PLAY;
      tick_n  = '0;
      pend_n  = '0;
      dir_n   = 1'b0;
      mode_n  = mode > MODE_PINGPONG ? MODE_ONCE : mode;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      tick      <= '0;
      pend      <= '0;
      disp      <= '0;
      dir       <= 1'b0;
      mode_r    <= MODE_ONCE;
      addr      <= '0;
      vld       <= '0;
      oled_data <= '0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      pend      <= pend_n;
      disp      <= disp_n;
      dir       <= dir_n;
      mode_r    <= mode_n;
      addr      <= valid ? AW'(disp_n) * NPIX_A + AW'(pixel_index) : '0;
      vld       <= {vld[1:0], valid};
      oled_data <= vld[2] ? douta : '0;
    end
  single_port_ram #(
    .RAM_WIDTH(PIX_BITS),
    .RAM_DEPTH(DEPTH),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
    .INIT_FILE(MEM_FILE)
  ) u_rom (
    .clka(clk),
    .addra(addr),
    .dina('0),
    .wea(1'b0),
    .ena(1'b1),
    .regcea(1'b1),
    .douta(douta)
  );
endmodule

// File: tb/tb_splash_player.sv
// tb_splash_player: randomized scan stimulus against a hold-index model of the splash sequencer.
module tb_splash_player;
  localparam int NF = 3;
  localparam int FT = 8;
  localparam int NP = 6144;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [12:0] pi = '0;
  logic st = 1'b0, sk = 1'b0;
  logic [1:0] md = '0;
  logic [15:0] oled_data;
  logic [1:0] frame;
  logic busy, done;
  int n_cmp = 0, n_fail = 0;
  int m_state, m_t, m_mode, m_pend, m_disp;
  logic [15:0] e_oled;
  logic [15:0] q[$];
  always #5 clk = ~clk;
  splash_player #(.N_FRAMES(NF), .FRAME_TICKS(FT)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_index(pi), .start(st), .skip(sk), .mode(md),
    .oled_data(oled_data), .frame(frame), .busy(busy), .done(done)
  );
  // Frame shown during hold period k for a given mode (0 once, 1 loop, 2 ping-pong).
  function automatic int seq(int m, int k);
    int r;
    if (m == 1) return k % NF;
    if (m == 2) begin
      if (NF == 1) return 0;
      r = k % (2 * (NF - 1));
      return r < NF ? r : 2 * (NF - 1) - r;
    end
    return k < NF - 1 ? k : NF - 1;
  endfunction
  task automatic model_reset();
    m_state = 0; m_t = 0; m_mode = 0; m_pend = 0; m_disp = 0;
    e_oled = '0;
    q.delete();
  endtask
  // Advance the model by one clock using the inputs currently driven, then step the DUT.
  task automatic cyc();
    int dn;
    logic [15:0] ep;
    dn = (pi == 0) ? m_pend : m_disp;
    ep = (int'(pi) < NP) ? {3'(dn), pi} : 16'h0;
    m_disp = dn;
    q.push_back(ep);
    if (q.size() > 4) void'(q.pop_front());
    if (m_state == 1) begin
      if (sk) begin
        m_state = 2;
        m_pend = NF - 1;
      end else begin
        m_t++;
        if (m_mode == 0 && m_t / FT >= NF) m_state = 2;
        else m_pend = seq(m_mode, m_t / FT);
      end
    end else if (st) begin
      m_state = 1; m_t = 0; m_pend = 0;
      m_mode = (md == 2'd3) ? 0 : int'(md);
    end
    @(posedge clk);
    #1;
    e_oled = (q.size() == 4) ? q[0] : 16'h0;
  endtask
  task automatic pulse_start(input logic [1:0] m);
    md = m; st = 1'b1; pi = 13'($urandom_range(1, NP - 1));
    cyc();
    st = 1'b0;
  endtask
  task automatic test_reset();
    n_cmp++;
    if ({oled_data, frame, busy, done} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_state got %h want 00000", {oled_data, frame, busy, done});
    end
    @(posedge clk); #1; rst_n = 1'b1;
    pi = 13'h0123;
    repeat (4) cyc();
    n_cmp++;
    if ({oled_data, busy, done} !== {16'h0123, 2'b00}) begin
      n_fail++;
      $display("FAIL idle_pixel got %h/%b%b want 0123/00", oled_data, busy, done);
    end
    pi = 13'd6144;
    repeat (4) cyc();
    n_cmp++;
    if (oled_data !== 16'h0) begin
      n_fail++;
      $display("FAIL out_of_range got %h want 0000", oled_data);
    end
  endtask
  task automatic test_once();
    pulse_start(2'd0);
    for (int c = 0; c < 40; c++) begin
      pi = (c % 16 == 0) ? 13'd0 : 13'($urandom_range(1, NP - 1));
      cyc();
      n_cmp++;
      if ({oled_data, frame, busy, done} !== {e_oled, 2'(m_disp), m_state == 1, m_state == 2}) begin
        n_fail++;
        $display("FAIL once c=%0d got %h want %h", c, {oled_data, frame, busy, done},
                 {e_oled, 2'(m_disp), m_state == 1, m_state == 2});
      end
    end
    n_cmp++;
    if ({done, busy, frame, oled_data[15:13]} !== {1'b1, 1'b0, 2'd2, 3'd2}) begin
      n_fail++;
      $display("FAIL once_end got done=%b busy=%b frame=%0d hi=%0d want 1 0 2 2",
               done, busy, frame, oled_data[15:13]);
    end
  endtask
  task automatic test_loop();
    int lst[5] = '{0, 1, 2, 0, 1};
    pulse_start(2'd1);
    for (int c = 0; c < 40; c++) begin
      pi = (c % 8 == 4) ? 13'd0 : 13'($urandom_range(1, 6300));
      cyc();
      n_cmp++;
      if ({oled_data, frame, busy, done} !== {e_oled, 2'(m_disp), m_state == 1, m_state == 2}) begin
        n_fail++;
        $display("FAIL loop c=%0d got %h want %h", c, {oled_data, frame, busy, done},
                 {e_oled, 2'(m_disp), m_state == 1, m_state == 2});
      end
      if (c % 8 == 4) begin
        n_cmp++;
        if (frame !== 2'(lst[c / 8])) begin
          n_fail++;
          $display("FAIL loop_seq k=%0d got %0d want %0d", c / 8, frame, lst[c / 8]);
        end
      end
    end
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_fail++;
      $display("FAIL loop_busy got %b%b want 10", busy, done);
    end
  endtask
  task automatic test_pingpong();
    int lst[6] = '{0, 1, 2, 1, 0, 1};
    sk = 1'b1; cyc(); sk = 1'b0;
    pulse_start(2'd2);
    for (int c = 0; c < 48; c++) begin
      pi = (c % 8 == 4) ? 13'd0 : 13'($urandom_range(1, 6300));
      cyc();
      n_cmp++;
      if ({oled_data, frame, busy, done} !== {e_oled, 2'(m_disp), m_state == 1, m_state == 2}) begin
        n_fail++;
        $display("FAIL pingpong c=%0d got %h want %h", c, {oled_data, frame, busy, done},
                 {e_oled, 2'(m_disp), m_state == 1, m_state == 2});
      end
      if (c % 8 == 4) begin
        n_cmp++;
        if (frame !== 2'(lst[c / 8])) begin
          n_fail++;
          $display("FAIL pingpong_seq k=%0d got %0d want %0d", c / 8, frame, lst[c / 8]);
        end
      end
    end
  endtask
  task automatic test_skip();
    sk = 1'b1; cyc(); sk = 1'b0;
    pulse_start(2'd0);
    for (int c = 0; c < 10; c++) begin
      pi = (c == 9) ? 13'd0 : 13'($urandom_range(1, NP - 1));
      cyc();
    end
    sk = 1'b1; pi = 13'd77;
    cyc();
    sk = 1'b0;
    n_cmp++;
    if ({done, busy, frame} !== {1'b1, 1'b0, 2'd1}) begin
      n_fail++;
      $display("FAIL skip_done got done=%b busy=%b frame=%0d want 1 0 1", done, busy, frame);
    end
    pi = 13'd0;
    cyc();
    n_cmp++;
    if (frame !== 2'd2) begin
      n_fail++;
      $display("FAIL skip_swap got %0d want 2", frame);
    end
    pi = 13'd5;
    repeat (4) cyc();
    n_cmp++;
    if (oled_data !== e_oled || oled_data !== {3'd2, 13'd5}) begin
      n_fail++;
      $display("FAIL skip_pixel got %h want %h", oled_data, {3'd2, 13'd5});
    end
  endtask
  task automatic test_start_skip();
    st = 1'b1; sk = 1'b1; md = 2'd1; pi = 13'd9;
    cyc();
    st = 1'b0; sk = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b10 || m_state != 1) begin
      n_fail++;
      $display("FAIL start_skip got busy=%b done=%b want 1 0", busy, done);
    end
    pi = 13'd0;
    cyc();
    n_cmp++;
    if (frame !== 2'd0) begin
      n_fail++;
      $display("FAIL start_skip_frame got %0d want 0", frame);
    end
  endtask
  task automatic test_reset_mid();
    for (int c = 0; c < 12; c++) begin
      pi = (c % 4 == 0) ? 13'd0 : 13'($urandom_range(1, NP - 1));
      cyc();
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({oled_data, frame, busy, done} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid got %h want 00000", {oled_data, frame, busy, done});
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      pi = (c % 5 == 0) ? 13'd0 : 13'($urandom_range(0, 6300));
      cyc();
      n_cmp++;
      if ({oled_data, frame, busy, done} !== {e_oled, 2'(m_disp), m_state == 1, m_state == 2}) begin
        n_fail++;
        $display("FAIL after_reset c=%0d got %h want %h", c, {oled_data, frame, busy, done},
                 {e_oled, 2'(m_disp), m_state == 1, m_state == 2});
      end
    end
  endtask
  initial begin
    for (int f = 0; f < NF; f++)
      for (int p = 0; p < NP; p++)
        dut.u_rom.ram[f * NP + p] = {3'(f), 13'(p)};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_once();
    test_loop();
    test_pingpong();
    test_skip();
    test_start_skip();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
